// File: rtl/hazard_detector_banked.sv
// Banked read-after-write hazard detector with per-bank pending tables.
// Optional HDU_STATS_EN adds saturating hazard/conflict event counters.
module hazard_detector_banked #(
    parameter int NUM_PORTS  = 8,
    parameter int ADDR_W     = 16,
    parameter int BANK_W     = 5,
    parameter int PEND_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*ADDR_W-1:0] raddr,
    input  logic [NUM_PORTS-1:0]        raddr_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0] waddr,
    input  logic [NUM_PORTS-1:0]        waddr_valid,
    output logic [NUM_PORTS-1:0]        flag_valid,
    output logic [NUM_PORTS-1:0]        hazard,
    output logic [NUM_PORTS-1:0]        conflict,
    output logic [(1<<BANK_W)-1:0]      bank_busy,
    output logic [31:0]                 hazard_cnt,
    output logic [31:0]                 conflict_cnt
);

    localparam int NB = 1 << BANK_W;
    localparam int TW = ADDR_W - BANK_W;

    logic [NB-1:0][PEND_DEPTH-1:0]         vld_q, vld_d;
    logic [NB-1:0][PEND_DEPTH-1:0][TW-1:0] tag_q, tag_d;
    logic [NUM_PORTS-1:0] fv_q, hz_q, hz_d, cf_q, cf_d;

    logic [NUM_PORTS-1:0][BANK_W-1:0] rbank, wbank;
    logic [NUM_PORTS-1:0][TW-1:0]     rtag, wtag;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rbank[i] = raddr[i*ADDR_W +: BANK_W];
            rtag[i]  = raddr[i*ADDR_W+BANK_W +: TW];
            wbank[i] = waddr[i*ADDR_W +: BANK_W];
            wtag[i]  = waddr[i*ADDR_W+BANK_W +: TW];
        end
    end

    always_comb begin
        logic lose;
        logic hit;
        logic found;
        logic [BANK_W-1:0] b;
        vld_d = vld_q;
        tag_d = tag_q;
        hz_d  = '0;
        cf_d  = '0;
        lose  = 1'b0;
        hit   = 1'b0;
        found = 1'b0;
        b     = '0;
        // Write-backs clear first so a same-cycle read sees the freed entry
        for (int bk = 0; bk < NB; bk++) begin
            for (int e = 0; e < PEND_DEPTH; e++) begin
                for (int w = 0; w < NUM_PORTS; w++) begin
                    if (waddr_valid[w] && (int'(wbank[w]) == bk)
                        && (wtag[w] == tag_q[bk][e]))
                        vld_d[bk][e] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            lose = 1'b0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                if ((j < i) && raddr_valid[j] && (rbank[j] == rbank[i]))
                    lose = 1'b1;
            end
            if (raddr_valid[i]) begin
                if (lose) begin
                    cf_d[i] = 1'b1;
                end else begin
                    b   = rbank[i];
                    hit = 1'b0;
                    for (int e = 0; e < PEND_DEPTH; e++) begin
                        if (vld_d[b][e] && (tag_q[b][e] == rtag[i]))
                            hit = 1'b1;
                    end
                    if (hit) begin
                        hz_d[i] = 1'b1;
                    end else begin
                        found = 1'b0;
                        for (int e = 0; e < PEND_DEPTH; e++) begin
                            if (!found && !vld_d[b][e]) begin
                                vld_d[b][e] = 1'b1;
                                tag_d[b][e] = rtag[i];
                                found = 1'b1;
                            end
                        end
                        if (!found)
                            cf_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            tag_q <= '0;
            fv_q  <= '0;
            hz_q  <= '0;
            cf_q  <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            fv_q  <= raddr_valid;
            hz_q  <= hz_d;
            cf_q  <= cf_d;
        end
    end

    always_comb begin
        for (int bk = 0; bk < NB; bk++)
            bank_busy[bk] = |vld_q[bk];
    end

    assign flag_valid = fv_q;
    assign hazard     = hz_q;
    assign conflict   = cf_q;

`ifdef HDU_STATS_EN
    function automatic logic [32:0] popc(input logic [NUM_PORTS-1:0] v);
        logic [32:0] n;
        n = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            n = n + {32'd0, v[i]};
        return n;
    endfunction

    logic [31:0] hcnt_q, ccnt_q;
    logic [32:0] hsum, csum;

    assign hsum = {1'b0, hcnt_q} + popc(hz_d);
    assign csum = {1'b0, ccnt_q} + popc(cf_d);

    // Counters advance on the same edge that registers the flags
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            ccnt_q <= '0;
        end else begin
            hcnt_q <= hsum[32] ? 32'hFFFF_FFFF : hsum[31:0];
            ccnt_q <= csum[32] ? 32'hFFFF_FFFF : csum[31:0];
        end
    end

    assign hazard_cnt   = hcnt_q;
    assign conflict_cnt = ccnt_q;
`else
    assign hazard_cnt   = '0;
    assign conflict_cnt = '0;
`endif

endmodule
